// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for an N-bit universal shift register: load a word, run len serial shifts, return result.
// Latency: done_tick 3+L cycles after accept (L = len clamped to N); abort ends early through DONE.
// Backpressure: cmd_ready is high only in IDLE; one command in flight, next accept possible in the done_tick cycle.
module shift_reg_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             ser_in,
  output logic [1:0]       sr_ctrl,
  output logic [N-1:0]     sr_d,
  input  logic [N-1:0]     sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [N-1:0]     rsp_data,
  output logic             done_tick,
  output logic             aborted,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0]       CTRL_HOLD = 2'b00;
  localparam logic [1:0]       CTRL_SHL  = 2'b01;
  localparam logic [1:0]       CTRL_SHR  = 2'b10;
  localparam logic [1:0]       CTRL_LOAD = 2'b11;
  localparam logic [CNT_W-1:0] LEN_MAX   = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [N-1:0]     data_r;
  logic             dir_r;
  logic [CNT_W-1:0] cnt;
  logic             abort_pend;
  logic             accept;
  logic             abort_hit;
  logic [CNT_W-1:0] len_clamped;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = cmd_valid & cmd_ready;
  // abort only matters while the datapath is being driven
  assign abort_hit   = abort & ((state == LOAD) | (state == SHIFT));
  // lengths beyond the register width would only shift in more ser_in bits; cap at N
  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and datapath drive; an aborted cycle holds the register untouched
  always_comb begin
    state_nxt = state;
    sr_ctrl   = CTRL_HOLD;
    sr_d      = '0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt = DONE;
        end else begin
          sr_ctrl   = CTRL_LOAD;
          sr_d      = data_r;
          state_nxt = (cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = DONE;
        end else begin
          ser_valid = 1'b1;
          if (dir_r) begin
            sr_ctrl = CTRL_SHR;
            sr_d    = {ser_in, {(N-1){1'b0}}};
            ser_out = sr_q[0];
          end else begin
            sr_ctrl = CTRL_SHL;
            sr_d    = {{(N-1){1'b0}}, ser_in};
            ser_out = sr_q[N-1];
          end
          if (cnt == CNT_ONE) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // latch the command on accept; count down once per performed shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= '0;
      dir_r  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      data_r <= cmd_data;
      dir_r  <= cmd_dir;
      cnt    <= len_clamped;
    end else if ((state == SHIFT) && !abort) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // remember an abort until DONE so aborted rises together with done_tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_pend <= 1'b0;
    end else if (accept) begin
      abort_pend <= 1'b0;
    end else if (abort_hit) begin
      abort_pend <= 1'b1;
    end
  end

  // response: capture the register in DONE, pulse done_tick the cycle after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data  <= '0;
      done_tick <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done_tick <= (state == DONE);
      if (state == DONE) begin
        rsp_data <= sr_q;
        aborted  <= abort_pend;
      end else if (accept) begin
        aborted <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: directed cases plus randomized commands against a word-level model.
// A simple universal shift register stands in for the datapath driven by sr_ctrl/sr_d.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_shift_reg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_len;
  logic       abort;
  logic       ser_in;
  logic [1:0] sr_ctrl;
  logic [7:0] sr_d;
  logic [7:0] sr_q = 8'h00;
  logic       ser_out;
  logic       ser_valid;
  logic [7:0] rsp_data;
  logic       done_tick;
  logic       aborted;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // expected datapath contents and last response, tracked at word level
  logic [7:0] model_dp  = 8'h00;
  logic [7:0] last_rsp  = 8'h00;

  shift_reg_sequencer #(.N(8), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .ser_in    (ser_in),
    .sr_ctrl   (sr_ctrl),
    .sr_d      (sr_d),
    .sr_q      (sr_q),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .rsp_data  (rsp_data),
    .done_tick (done_tick),
    .aborted   (aborted),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // stand-in universal shift register
  always_ff @(posedge clk) begin
    case (sr_ctrl)
      2'b01:   sr_q <= {sr_q[6:0], sr_d[0]};
      2'b10:   sr_q <= {sr_d[7], sr_q[7:1]};
      2'b11:   sr_q <= sr_d;
      default: sr_q <= sr_q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One command from accept (cycle 0) to done_tick (cycle D).
  // abort_at: cycle index to raise abort (-1 none). sin_mode: 0 zeros, 1 ones, 2 random.
  // chained: cycle 0 is the current cycle (previous command's done_tick cycle).
  task automatic run_cmd(input logic [7:0] data, input logic dir, input int len,
                         input int abort_at, input int sin_mode, input bit chained);
    int         L;
    int         D;
    bit         ab;
    bit         shifting;
    logic [7:0] v;
    logic       sin [0:31];
    logic       exp_bits [$];
    logic [1:0] exp_ctrl;
    logic [7:0] exp_d;
    logic       exp_out;

    L  = (len > 8) ? 8 : len;
    ab = (abort_at >= 1) && (abort_at <= 1 + L);
    D  = ab ? abort_at + 2 : 3 + L;
    for (int c = 0; c < 32; c++) begin
      sin[c] = (sin_mode == 0) ? 1'b0 : (sin_mode == 1) ? 1'b1 : 1'($urandom_range(1));
    end

    // word-level reference: start from loaded data (or untouched contents if load aborted)
    v = (ab && abort_at == 1) ? model_dp : data;
    for (int c = 2; c < 2 + L; c++) begin
      if (ab && c >= abort_at) break;
      if (!dir) begin
        exp_bits.push_back(v[7]);
        v = {v[6:0], sin[c]};
      end else begin
        exp_bits.push_back(v[0]);
        v = {sin[c], v[7:1]};
      end
    end

    if (!chained) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_len   = 4'(len);
    abort     = 1'b0;
    ser_in    = 1'($urandom_range(1));
    #1;
    check("accept_ready", 32'(cmd_ready), 32'(1));
    if (!chained) check("idle_tick", 32'(done_tick), 32'(0));

    for (int c = 1; c <= D; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
      cmd_dir   = 1'($urandom_range(1));
      cmd_len   = 4'($urandom);
      abort     = (c == abort_at);
      ser_in    = sin[c];
      #1;
      shifting = (c >= 2) && (c < 2 + L) && !(ab && c >= abort_at);
      exp_ctrl = 2'b00;
      exp_d    = 8'h00;
      exp_out  = 1'b0;
      if (c == 1 && !(ab && abort_at == 1)) begin
        exp_ctrl = 2'b11;
        exp_d    = data;
      end else if (shifting) begin
        exp_ctrl = dir ? 2'b10 : 2'b01;
        exp_d    = dir ? {sin[c], 7'b0} : {7'b0, sin[c]};
        exp_out  = exp_bits[c-2];
      end
      check("sr_ctrl", 32'(sr_ctrl), 32'(exp_ctrl));
      check("sr_d", 32'(sr_d), 32'(exp_d));
      check("ser_valid", 32'(ser_valid), 32'(shifting));
      check("ser_out", 32'(ser_out), 32'(exp_out));
      check("busy", 32'(busy), 32'(c < D));
      check("done_tick", 32'(done_tick), 32'(c == D));
      if (c < D) begin
        check("rsp_hold", 32'(rsp_data), 32'(last_rsp));
        check("aborted_clr", 32'(aborted), 32'(0));
      end else begin
        check("rsp_data", 32'(rsp_data), 32'(v));
        check("aborted", 32'(aborted), 32'(ab));
      end
    end
    abort    = 1'b0;
    last_rsp = v;
    model_dp = v;
  endtask

  initial begin
    int len;
    int L;
    int ab_at;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_dir   = 1'b0;
    cmd_len   = 4'd0;
    abort     = 1'b0;
    ser_in    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl", 32'(sr_ctrl), 32'(0));
    check("rst_d", 32'(sr_d), 32'(0));
    check("rst_rsp", 32'(rsp_data), 32'(0));
    check("rst_tick", 32'(done_tick), 32'(0));
    check("rst_aborted", 32'(aborted), 32'(0));
    check("rst_ser_valid", 32'(ser_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    reset = 1'b0;

    // directed cases
    run_cmd(8'hA5, 1'b0, 4,  -1, 1, 1'b0);
    run_cmd(8'hA5, 1'b1, 3,  -1, 0, 1'b0);
    run_cmd(8'h3C, 1'b0, 0,  -1, 2, 1'b0);
    run_cmd(8'hC7, 1'b0, 15, -1, 0, 1'b0);
    run_cmd(8'hFF, 1'b0, 6,   3, 0, 1'b0);
    run_cmd(8'h12, 1'b1, 5,   1, 2, 1'b0);
    run_cmd(8'h5A, 1'b1, 2,   4, 2, 1'b0);
    // back-to-back: next accept in the done_tick cycle
    run_cmd(8'h96, 1'b0, 3,  -1, 2, 1'b0);
    run_cmd(8'h69, 1'b1, 5,  -1, 2, 1'b1);
    run_cmd(8'hE1, 1'b0, 0,  -1, 2, 1'b1);

    // reset in the middle of SHIFT
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_dir = 1'b0; cmd_len = 4'd6; abort = 1'b0; ser_in = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_ctrl", 32'(sr_ctrl), 32'(2'b01));
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_ctrl", 32'(sr_ctrl), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_ready", 32'(cmd_ready), 32'(1));
    check("midrst_valid", 32'(ser_valid), 32'(0));
    check("midrst_rsp", 32'(rsp_data), 32'(0));
    @(negedge clk);
    reset    = 1'b0;
    model_dp = 8'hFE;
    last_rsp = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("postrst_tick", 32'(done_tick), 32'(0));
      check("postrst_busy", 32'(busy), 32'(0));
    end
    run_cmd(8'h81, 1'b1, 4, -1, 2, 1'b0);

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      len   = int'($urandom_range(15));
      L     = (len > 8) ? 8 : len;
      ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(2 + L, 1)) : -1;
      run_cmd(8'($urandom), 1'($urandom_range(1)), len, ab_at, 2, 1'($urandom_range(1)));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
